regfile_read_sel: RTL and testbench

- Parametrised multi-port read stage for the register file of the static pipeline CPU.
- Takes the flattened register-file contents (DEPTH x DATA_W words) and NPORTS read addresses.
- Returns one word per port through a single registered pipeline stage.
- Handles the hardwired-zero register, stall hold and flush; optionally forwards same-cycle write-back data.

---
 rtl/regfile_read_sel.sv | 77 +++++++
 tb/tb_regfile_read_sel.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_sel.sv
// Registered multi-port read stage for the pipeline register file.
// Define REGFILE_READ_SEL_BYPASS_EN to forward same-cycle write-back data into the read ports.
module regfile_read_sel #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NPORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DEPTH*DATA_W-1:0]    idata,
    input  logic [NPORTS*ADDR_W-1:0]   raddr,
    input  logic                       rd_valid_in,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       wena,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [NPORTS*DATA_W-1:0]   rdata,
    output logic                       rd_valid_out
);

    logic [NPORTS*DATA_W-1:0] rdata_d, rdata_q;
    logic                     rd_valid_d, rd_valid_q;

`ifdef REGFILE_READ_SEL_BYPASS_EN
    logic [NPORTS-1:0] bypass_hit;

    always_comb begin
        bypass_hit = '0;
        for (int p = 0; p < NPORTS; p++) begin
            bypass_hit[p] = wena && (waddr == raddr[p*ADDR_W +: ADDR_W]) &&
                            (waddr != '0) && (32'(waddr) < DEPTH);
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wena, waddr, wdata};
`endif

    // Register 0 and out-of-range addresses never match a word, so they read as zero.
    always_comb begin
        rdata_d = '0;
        for (int p = 0; p < NPORTS; p++) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (raddr[p*ADDR_W +: ADDR_W] == ADDR_W'(k)) begin
                    rdata_d[p*DATA_W +: DATA_W] = idata[k*DATA_W +: DATA_W];
                end
            end
`ifdef REGFILE_READ_SEL_BYPASS_EN
            if (bypass_hit[p]) begin
                rdata_d[p*DATA_W +: DATA_W] = wdata;
            end
`endif
        end
    end

    assign rd_valid_d = rd_valid_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else if (flush) begin
            rd_valid_q <= 1'b0;
        end else if (!stall) begin
            rd_valid_q <= rd_valid_d;
            if (rd_valid_in) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign rdata        = rdata_q;
    assign rd_valid_out = rd_valid_q;

endmodule

// File: tb/tb_regfile_read_sel.sv
// Randomised scoreboard bench: default instance plus a 16-bit/16-deep/3-port instance.
module tb_regfile_read_sel;

    logic          clk = 1'b0;
    logic          rst, rd_valid_in, stall, flush, wena;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic [1023:0] idata;
    logic [9:0]    raddr;
    logic [63:0]   rdata;
    logic          rd_valid_out;
    logic [255:0]  idata2;
    logic [14:0]   raddr2;
    logic [47:0]   rdata2;
    logic          rd_valid_out2;

    logic [31:0] regs [32];
    logic [15:0] regs2 [16];

    // Reference state: what the outputs must show after the next edge
    logic        mv, sv;
    logic [31:0] md [2];
    logic [15:0] sd [3];

    typedef struct packed {
        logic        mv;
        logic [63:0] md;
        logic        sv;
        logic [47:0] sd;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_bad = 0;

`ifdef REGFILE_READ_SEL_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 32; k++) idata[k*32 +: 32] = regs[k];
        for (int k = 0; k < 16; k++) idata2[k*16 +: 16] = regs2[k];
    end

    regfile_read_sel u_dut (
        .clk          (clk),
        .rst          (rst),
        .idata        (idata),
        .raddr        (raddr),
        .rd_valid_in  (rd_valid_in),
        .stall        (stall),
        .flush        (flush),
        .wena         (wena),
        .waddr        (waddr),
        .wdata        (wdata),
        .rdata        (rdata),
        .rd_valid_out (rd_valid_out)
    );

    regfile_read_sel #(
        .DATA_W (16),
        .ADDR_W (5),
        .DEPTH  (16),
        .NPORTS (3)
    ) u_dut_sweep (
        .clk          (clk),
        .rst          (rst),
        .idata        (idata2),
        .raddr        (raddr2),
        .rd_valid_in  (rd_valid_in),
        .stall        (stall),
        .flush        (flush),
        .wena         (wena),
        .waddr        (waddr),
        .wdata        (wdata[15:0]),
        .rdata        (rdata2),
        .rd_valid_out (rd_valid_out2)
    );

    function automatic logic [31:0] ref32(input int a);
        if (a == 0 || a >= 32) return 32'h0;
        if (Byp && wena && int'(waddr) == a) return wdata;
        return regs[a];
    endfunction

    function automatic logic [15:0] ref16(input int a);
        if (a == 0 || a >= 16) return 16'h0;
        if (Byp && wena && int'(waddr) == a) return wdata[15:0];
        return regs2[a];
    endfunction

    // Advance the reference by one edge using the inputs currently driven, then clock.
    task automatic step();
        exp_t e;
        if (rst) begin
            mv = 1'b0; sv = 1'b0;
            foreach (md[p]) md[p] = '0;
            foreach (sd[p]) sd[p] = '0;
        end else if (flush) begin
            mv = 1'b0; sv = 1'b0;
        end else if (!stall) begin
            mv = rd_valid_in; sv = rd_valid_in;
            if (rd_valid_in) begin
                foreach (md[p]) md[p] = ref32(int'(raddr[p*5 +: 5]));
                foreach (sd[p]) sd[p] = ref16(int'(raddr2[p*5 +: 5]));
            end
        end
        e.mv = mv;
        e.md = {md[1], md[0]};
        e.sv = sv;
        e.sd = {sd[2], sd[1], sd[0]};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (rd_valid_out !== e.mv || rdata !== e.md) begin
                    n_bad++;
                    $display("FAIL main t=%0t got v=%0b d=%h exp v=%0b d=%h",
                             $time, rd_valid_out, rdata, e.mv, e.md);
                end
                n_vec++;
                if (rd_valid_out2 !== e.sv || rdata2 !== e.sd) begin
                    n_bad++;
                    $display("FAIL sweep t=%0t got v=%0b d=%h exp v=%0b d=%h",
                             $time, rd_valid_out2, rdata2, e.sv, e.sd);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; rd_valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
        wena = 1'b0; waddr = '0; wdata = '0; raddr = '0; raddr2 = '0;
        foreach (regs[k]) regs[k] = $urandom;
        foreach (regs2[k]) regs2[k] = 16'($urandom);
        step();
        step();

        rst = 1'b0;
        foreach (regs[k]) regs[k] = 32'h1000_0000 + k;
        raddr = {5'd7, 5'd3};
        raddr2 = {5'd20, 5'd15, 5'd1};
        rd_valid_in = 1'b1;
        step();

        regs[0] = 32'hDEAD_BEEF;
        raddr = {5'd0, 5'd0};
        step();

        raddr = {5'd5, 5'd6};
        step();
        stall = 1'b1;
        raddr = {5'd9, 5'd10};
        raddr2 = {5'd2, 5'd3, 5'd4};
        repeat (3) step();
        stall = 1'b0;
        step();

        stall = 1'b1; flush = 1'b1;
        raddr = {5'd11, 5'd12};
        step();
        stall = 1'b0; flush = 1'b0;

        wena = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_0004;
        regs[4] = 32'h1111_1111;
        raddr = {5'd4, 5'd8};
        raddr2 = {5'd4, 5'd0, 5'd8};
        step();
        waddr = 5'd0;
        raddr = {5'd0, 5'd0};
        raddr2 = {5'd0, 5'd0, 5'd0};
        step();
        wena = 1'b0;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 31)] = $urandom;
            if ($urandom_range(0, 3) == 0) regs2[$urandom_range(0, 15)] = 16'($urandom);
            raddr  = 10'($urandom);
            raddr2 = 15'($urandom);
            rd_valid_in = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 39) == 0);
            wena  = $urandom_range(0, 1) == 1;
            waddr = ($urandom_range(0, 1) == 1) ? raddr[4:0] : 5'($urandom);
            wdata = $urandom;
            step();
        end

        rd_valid_in = 1'b0; stall = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (5) begin
            if (q.size() != 0) @(posedge clk);
        end
        #3;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
